alu_sequencer: RTL
==================

# alu_sequencer

Multi-cycle issue and capture controller wrapped around the 32-bit ALU.
- Accepts an encoded operation and two operands through a valid/ready handshake.
- Drives the ALU's one-hot operation lines and A/B operands for the op-dependent latency.
- Captures the ALU's 64-bit result into split Z high/low registers and pulses `done`.
- Sits between the control unit (upstream) and the ALU, with Z feeding the bus downstream.

## Interface
- `MUL_LAT`, default 10: WAIT cycles for MUL.
- `DIV_LAT`, default 34: WAIT cycles for DIV.
- `clk`, input, 1: rising-edge clock.
- `clr_n`, input, 1: reset, asynchronous, active-low.
- `req_valid`, input, 1: request present.
- `req_ready`, output, 1: sequencer can accept a request; high only in IDLE.
- `req_op`, input, 4: opcode.
  - 0 AND, 1 OR, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 SHR.
  - 7 SHL, 8 ROR, 9 ROL, 10 NEG, 11 NOT, 12 INCPC.
  - 13–15 illegal.
- `req_a`, input, 32: operand A.
- `req_b`, input, 32: operand B.
- `alu_a`, output, 32: registered operand A to the ALU.
- `alu_b`, output, 32: registered operand B to the ALU.
- `op_sel`, output, 13: one-hot ALU op lines; bit index equals opcode.
- `alu_c`, input, 64: ALU result.
- `z_hi`, output, 32: captured `alu_c[63:32]`.
- `z_lo`, output, 32: captured `alu_c[31:0]`.
- `done`, output, 1: one-cycle pulse when Z is updated.
- `err`, output, 1: one-cycle pulse on an illegal opcode.
- `busy`, output, 1: high when not in IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch `req_a`, `req_b` and the opcode.
  - Legal opcode: go to ISSUE.
  - Illegal opcode: stay in IDLE, pulse `err` next cycle; no ALU lines asserted, Z unchanged.
- ISSUE: `op_sel` = one-hot(op) for one cycle; load the latency counter with L.
  - L = MUL_LAT for MUL.
  - L = DIV_LAT for DIV.
  - L = 1 for every other op.
- WAIT: `op_sel` held asserted; counter decrements each cycle; leave for CAPTURE when the count reaches 0 (exactly L cycles).
- CAPTURE:
  - `op_sel`=0.
  - On the exiting edge: `z_hi`/`z_lo` <= `alu_c`, `done` <= 1, go to IDLE.
- `alu_a`/`alu_b` are stable from ISSUE through CAPTURE and change only at acceptance.
- `op_sel` is never multi-hot; it is all zero in IDLE and CAPTURE.
- Z is a plain split of `alu_c`; the sequencer does no sign or width manipulation.
- Z holds its value until the next CAPTURE.

## Timing
- Acceptance edge E0 (`req_valid` & `req_ready`).
- ISSUE occupies cycle E0→E1; WAIT occupies E1→E(1+L); CAPTURE occupies E(1+L)→E(2+L).
- Z updates and `done` rises at E(2+L).
- Latency from acceptance to Z valid: L+2 cycles, i.e. 3 for simple ops, MUL_LAT+2 for MUL, DIV_LAT+2 for DIV.
- `req_ready` returns high at E(2+L), coincident with `done`.
  - A request accepted at the next edge overlaps the `done` cycle with no bubble.
- Illegal opcode: `err` is high in the cycle after acceptance and `req_ready` stays high (back-to-back accepts allowed).
- `req_valid` while busy: ignored, not queued; requester holds it until `req_ready`.
- Reset (`clr_n`=0, any time, including mid-WAIT), asynchronous:
  - State goes to IDLE and the counter to 0.
  - `op_sel`, `alu_a`, `alu_b`, `z_hi`, `z_lo`, `done`, `err` all go to 0.
  - `busy`=0, `req_ready`=1 (combinational from IDLE).
  - An interrupted op produces no `done`.
- All outputs except `req_ready` and `busy` are registered.

## Structure
- Shared package `alu_seq_pkg`:
  - Opcode constants 0–12 and the op count (13).
  - State enum.
  - Function `op_latency(op, MUL_LAT, DIV_LAT)`.
- Sub-module `lat_counter`: loadable down-counter, 6 bits, with `load`, `value` and `zero` outputs; instantiated once.
- Top: the FSM, operand/op latches, Z registers and output decode.

## Test plan
- ADD, A=5, B=7, ALU model returns 12:
  - `op_sel`=0x004 from E0 through E2.
  - `done` at E3 with `z_lo`=12, `z_hi`=0.
- MUL with MUL_LAT=10, A=0x10000, B=0x10000:
  - `op_sel`=0x010 for 11 cycles.
  - `done` at E12 with `z_hi`=1, `z_lo`=0.
  - `req_ready`=0 throughout.
- Illegal opcode 14:
  - `err` pulses once; `op_sel` stays 0; Z is unchanged.
  - A second request accepted at the next edge completes normally.
- Back-to-back AND then INCPC (B=0x100):
  - The second request is accepted on the `done` edge of the first.
  - Two `done` pulses 3 cycles apart, ending with `z_lo`=0x104.
- DIV mid-WAIT, `clr_n` pulled low asynchronously (between edges):
  - All outputs go to 0 immediately, with no `done`.
  - After release, `req_ready`=1 and a fresh SUB (9−4) gives `z_lo`=5.
- Request held while busy:
  - `req_valid` asserted during WAIT with a different op is not accepted.
  - It is accepted only at the `done` edge; `alu_a`/`alu_b` stay unchanged until then.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU issue/capture sequencer: opcodes, FSM states
// and the per-opcode latency lookup.
package alu_seq_pkg;

  localparam int OP_W    = 4;
  localparam int NUM_OPS = 13;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 6;

  localparam logic [OP_W-1:0] OP_AND   = 4'd0;
  localparam logic [OP_W-1:0] OP_OR    = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD   = 4'd2;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd3;
  localparam logic [OP_W-1:0] OP_MUL   = 4'd4;
  localparam logic [OP_W-1:0] OP_DIV   = 4'd5;
  localparam logic [OP_W-1:0] OP_SHR   = 4'd6;
  localparam logic [OP_W-1:0] OP_SHL   = 4'd7;
  localparam logic [OP_W-1:0] OP_ROR   = 4'd8;
  localparam logic [OP_W-1:0] OP_ROL   = 4'd9;
  localparam logic [OP_W-1:0] OP_NEG   = 4'd10;
  localparam logic [OP_W-1:0] OP_NOT   = 4'd11;
  localparam logic [OP_W-1:0] OP_INCPC = 4'd12;
  // Highest legal opcode; 13..15 are rejected with err.
  localparam logic [OP_W-1:0] OP_LAST  = OP_INCPC;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE
  } state_t;

  // Number of WAIT cycles the ALU needs for a given opcode.
  function automatic logic [CNT_W-1:0] op_latency(input logic [OP_W-1:0] op,
                                                  input int mul_lat,
                                                  input int div_lat);
    logic [CNT_W-1:0] lat;
    case (op)
      OP_MUL:  lat = CNT_W'(mul_lat);
      OP_DIV:  lat = CNT_W'(div_lat);
      default: lat = CNT_W'(1);
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request channel from the control unit into the sequencer (valid/ready).
interface alu_sequencer_if;
  import alu_seq_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;

  // Requester side (control unit).
  modport master (
    output req_valid,
    output req_op,
    output req_a,
    output req_b,
    input  req_ready
  );

  // Sequencer side.
  modport slave (
    input  req_valid,
    input  req_op,
    input  req_a,
    input  req_b,
    output req_ready
  );
endinterface

// File: rtl/alu_sequencer_lat_counter.sv
// Loadable down-counter that times the ALU's WAIT phase.
module lat_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  // Load has priority; decrement saturates at zero so a zero latency cannot wrap.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign value = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Issue/capture controller around the 32-bit ALU: accepts one request, holds
// the one-hot op lines for the op latency, then splits the 64-bit result into Z.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MUL_LAT = 10,
  parameter int DIV_LAT = 34
) (
  input  logic                clk,
  input  logic                clr_n,
  alu_sequencer_if.slave      req,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [NUM_OPS-1:0]  op_sel,
  input  logic [2*DATA_W-1:0] alu_c,
  output logic [DATA_W-1:0]   z_hi,
  output logic [DATA_W-1:0]   z_lo,
  output logic                done,
  output logic                err,
  output logic                busy
);

  state_t               state_reg, state_next;
  logic [OP_W-1:0]      op_reg, op_next;
  logic [DATA_W-1:0]    a_reg, a_next;
  logic [DATA_W-1:0]    b_reg, b_next;
  logic [NUM_OPS-1:0]   op_sel_reg, op_sel_next;
  logic [DATA_W-1:0]    z_hi_reg, z_hi_next;
  logic [DATA_W-1:0]    z_lo_reg, z_lo_next;
  logic                 done_reg, done_next;
  logic                 err_reg, err_next;

  logic                 cnt_load;
  logic                 cnt_dec;
  logic [CNT_W-1:0]     cnt_value;
  logic                 cnt_zero;
  logic                 req_legal;
  logic [NUM_OPS-1:0]   req_onehot;
  logic                 wait_last;

  // One-hot decode of the incoming opcode; illegal codes decode to all zero.
  for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_onehot
    assign req_onehot[gi] = (req.req_op == OP_W'(gi));
  end

  assign req_legal = (req.req_op <= OP_LAST);

  // Leave WAIT on the edge where the count drops to zero; the zero flag also
  // covers a latency parameter of 0, which would otherwise stall the FSM.
  assign wait_last = cnt_zero || (cnt_value == CNT_W'(1));

  lat_counter #(
    .WIDTH(CNT_W)
  ) u_lat_counter (
    .clk       (clk),
    .clr_n     (clr_n),
    .load      (cnt_load),
    .dec       (cnt_dec),
    .load_value(op_latency(op_reg, MUL_LAT, DIV_LAT)),
    .value     (cnt_value),
    .zero      (cnt_zero)
  );

  // State and datapath registers; reset clears everything so an interrupted op never completes.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg  <= ST_IDLE;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      op_sel_reg <= '0;
      z_hi_reg   <= '0;
      z_lo_reg   <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      op_sel_reg <= op_sel_next;
      z_hi_reg   <= z_hi_next;
      z_lo_reg   <= z_lo_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

  // Next-state and next-register logic; op_sel is set at acceptance so it is
  // already valid throughout ISSUE, and cleared on the way into CAPTURE.
  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    op_sel_next = op_sel_reg;
    z_hi_next   = z_hi_reg;
    z_lo_next   = z_lo_reg;
    done_next   = 1'b0;
    err_next    = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (req.req_valid) begin
          op_next = req.req_op;
          a_next  = req.req_a;
          b_next  = req.req_b;
          if (req_legal) begin
            op_sel_next = req_onehot;
            state_next  = ST_ISSUE;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        cnt_load   = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_dec = 1'b1;
        if (wait_last) begin
          op_sel_next = '0;
          state_next  = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        z_hi_next  = alu_c[2*DATA_W-1:DATA_W];
        z_lo_next  = alu_c[DATA_W-1:0];
        done_next  = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        op_sel_next = '0;
        state_next  = ST_IDLE;
      end
    endcase
  end

  assign req.req_ready = (state_reg == ST_IDLE);
  assign busy          = (state_reg != ST_IDLE);
  assign alu_a         = a_reg;
  assign alu_b         = b_reg;
  assign op_sel        = op_sel_reg;
  assign z_hi          = z_hi_reg;
  assign z_lo          = z_lo_reg;
  assign done          = done_reg;
  assign err           = err_reg;

endmodule
